// File: rtl/ace_fetch_pkg.sv
// Shared types and constants for the ace_fetch front-end fetch controller.
package ace_fetch_pkg;

  localparam int FETCH_WIDTH     = 8;
  localparam int FETCH_BLK_BYTES = 32;
  localparam int INST_W          = 32;
  localparam int BLK_W           = FETCH_WIDTH * INST_W;

  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

  typedef enum logic [1:0] {
    REQ     = 2'd0,
    WAIT    = 2'd1,
    PRESENT = 2'd2,
    DRAIN   = 2'd3
  } fetch_state_e;

  // Word offset of a PC inside its 32-byte fetch block.
  function automatic logic [2:0] blk_slot(input logic [4:0] pc_lo);
    blk_slot = pc_lo[4:2];
  endfunction

endpackage

// File: rtl/ace_fetch_chk.sv
// Protocol checker for ace_fetch: icache responses may only arrive while one is outstanding.
module ace_fetch_chk
  import ace_fetch_pkg::*;
(
  input logic       clock,
  input logic       reset_n,
  input logic [1:0] state_i,
  input logic       rsp_vld_i
);

  rsp_in_wait_or_drain_a : assert property (
    @(posedge clock) disable iff (!reset_n)
      rsp_vld_i |-> ((state_i == WAIT) || (state_i == DRAIN))
  ) else $error("ace_fetch: icache response with no request outstanding");

endmodule

// File: rtl/ace_fetch_slot_mask.sv
// Valid mask for a fetch block entered at a given slot: slots below the entry point are invalid.
module fetch_slot_mask
  import ace_fetch_pkg::*;
(
  input  logic [2:0]             slot_i,
  output logic [FETCH_WIDTH-1:0] mask_o
);

  // Slot i is valid when it lies at or after the entry slot.
  always_comb begin
    mask_o = {FETCH_WIDTH{1'b0}};
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      mask_o[i] = (3'(i) >= slot_i);
    end
  end

endmodule

// File: rtl/ace_fetch.sv
// Fetch controller: requests 32-byte blocks from the icache and presents up to eight
// instructions per packet to the decode instruction buffer, with flush redirect.
module ace_fetch
  import ace_fetch_pkg::*;
#(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            retire_flush_i,
  input  logic [PC_W-1:0] flush_pc_i,
  input  logic            instbuf_full_i,
  output logic            ic_req_o,
  output logic [PC_W-1:0] ic_addr_o,
  input  logic            ic_gnt_i,
  input  logic            ic_rsp_vld_i,
  input  logic [255:0]    ic_rsp_data_i,
  output logic [31:0]     fetch_inst0_o,
  output logic [31:0]     fetch_inst1_o,
  output logic [31:0]     fetch_inst2_o,
  output logic [31:0]     fetch_inst3_o,
  output logic [31:0]     fetch_inst4_o,
  output logic [31:0]     fetch_inst5_o,
  output logic [31:0]     fetch_inst6_o,
  output logic [31:0]     fetch_inst7_o,
  output logic            fetch_inst0_vld_o,
  output logic            fetch_inst1_vld_o,
  output logic            fetch_inst2_vld_o,
  output logic            fetch_inst3_vld_o,
  output logic            fetch_inst4_vld_o,
  output logic            fetch_inst5_vld_o,
  output logic            fetch_inst6_vld_o,
  output logic            fetch_inst7_vld_o,
  output logic            pipe_load_decode_o
);

  fetch_state_e           state_q, state_d;
  logic [PC_W-1:0]        pc_q, pc_d;
  logic [BLK_W-1:0]       data_q, data_d;
  logic [FETCH_WIDTH-1:0] vld_q, vld_d;

  logic [PC_W-1:0]        blk_base_s;
  logic [FETCH_WIDTH-1:0] slot_mask_s;
  logic                   load_s;
  logic                   flush_pc_unused_s;

  assign blk_base_s        = {pc_q[PC_W-1:5], 5'b00000};
  assign flush_pc_unused_s = ^flush_pc_i[1:0];

  fetch_slot_mask u_slot_mask (
    .slot_i (blk_slot(pc_q[4:0])),
    .mask_o (slot_mask_s)
  );

  // Next-state, PC, packet and valid-bit logic; a flush overrides normal progress.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    data_d  = data_q;
    vld_d   = vld_q;
    load_s  = 1'b0;
    if (retire_flush_i) begin
      pc_d  = {flush_pc_i[PC_W-1:2], 2'b00};
      vld_d = {FETCH_WIDTH{1'b0}};
      // A request granted in the flush cycle is outstanding and must be drained.
      case (state_q)
        REQ:         state_d = ic_gnt_i ? DRAIN : REQ;
        WAIT, DRAIN: state_d = ic_rsp_vld_i ? REQ : DRAIN;
        PRESENT:     state_d = REQ;
        default:     state_d = REQ;
      endcase
    end else begin
      case (state_q)
        REQ: begin
          if (ic_gnt_i) begin
            state_d = WAIT;
          end else begin
            state_d = REQ;
          end
        end
        WAIT: begin
          if (ic_rsp_vld_i) begin
            data_d  = ic_rsp_data_i;
            vld_d   = slot_mask_s;
            state_d = PRESENT;
          end else begin
            state_d = WAIT;
          end
        end
        PRESENT: begin
          if (!instbuf_full_i) begin
            load_s  = 1'b1;
            pc_d    = blk_base_s + PC_W'(FETCH_BLK_BYTES);
            vld_d   = {FETCH_WIDTH{1'b0}};
            state_d = REQ;
          end else begin
            state_d = PRESENT;
          end
        end
        DRAIN: begin
          if (ic_rsp_vld_i) begin
            state_d = REQ;
          end else begin
            state_d = DRAIN;
          end
        end
        default: state_d = REQ;
      endcase
    end
  end

  // All architectural state, with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      data_q  <= {BLK_W{1'b0}};
      vld_q   <= {FETCH_WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
    end
  end

  assign ic_req_o           = reset_n & (state_q == REQ);
  assign ic_addr_o          = blk_base_s;
  assign pipe_load_decode_o = reset_n & load_s;

  assign fetch_inst0_o = data_q[31:0];
  assign fetch_inst1_o = data_q[63:32];
  assign fetch_inst2_o = data_q[95:64];
  assign fetch_inst3_o = data_q[127:96];
  assign fetch_inst4_o = data_q[159:128];
  assign fetch_inst5_o = data_q[191:160];
  assign fetch_inst6_o = data_q[223:192];
  assign fetch_inst7_o = data_q[255:224];

  assign fetch_inst0_vld_o = vld_q[0];
  assign fetch_inst1_vld_o = vld_q[1];
  assign fetch_inst2_vld_o = vld_q[2];
  assign fetch_inst3_vld_o = vld_q[3];
  assign fetch_inst4_vld_o = vld_q[4];
  assign fetch_inst5_vld_o = vld_q[5];
  assign fetch_inst6_vld_o = vld_q[6];
  assign fetch_inst7_vld_o = vld_q[7];

  ace_fetch_chk u_chk (
    .clock     (clock),
    .reset_n   (reset_n),
    .state_i   (state_q),
    .rsp_vld_i (ic_rsp_vld_i)
  );

endmodule

// File: tb/tb_ace_fetch.sv
// Self-checking bench for ace_fetch: directed scenarios plus randomized traffic against a
// transaction-level reference model.
module tb_ace_fetch;

  localparam logic [63:0] RESET_PC_TB = 64'h1000;

  logic         clock;
  logic         reset_n;
  logic         retire_flush;
  logic [63:0]  flush_pc;
  logic         instbuf_full;
  logic         ic_req;
  logic [63:0]  ic_addr;
  logic         ic_gnt;
  logic         ic_rsp_vld;
  logic [255:0] ic_rsp_data;
  logic [31:0]  inst0, inst1, inst2, inst3, inst4, inst5, inst6, inst7;
  logic         v0, v1, v2, v3, v4, v5, v6, v7;
  logic         load;
  logic [255:0] inst_all;
  logic [7:0]   vld_all;

  int checks = 0;
  int errors = 0;

  // reference model: mode 0 requesting, 1 awaiting data, 2 holding packet, 3 discarding
  int           m_st;
  logic [63:0]  m_pc;
  logic [255:0] m_data;
  logic [7:0]   m_vld;

  assign inst_all = {inst7, inst6, inst5, inst4, inst3, inst2, inst1, inst0};
  assign vld_all  = {v7, v6, v5, v4, v3, v2, v1, v0};

  ace_fetch #(.PC_W(64), .RESET_PC(RESET_PC_TB)) dut (
    .clock(clock), .reset_n(reset_n), .retire_flush_i(retire_flush), .flush_pc_i(flush_pc),
    .instbuf_full_i(instbuf_full), .ic_req_o(ic_req), .ic_addr_o(ic_addr), .ic_gnt_i(ic_gnt),
    .ic_rsp_vld_i(ic_rsp_vld), .ic_rsp_data_i(ic_rsp_data),
    .fetch_inst0_o(inst0), .fetch_inst1_o(inst1), .fetch_inst2_o(inst2), .fetch_inst3_o(inst3),
    .fetch_inst4_o(inst4), .fetch_inst5_o(inst5), .fetch_inst6_o(inst6), .fetch_inst7_o(inst7),
    .fetch_inst0_vld_o(v0), .fetch_inst1_vld_o(v1), .fetch_inst2_vld_o(v2), .fetch_inst3_vld_o(v3),
    .fetch_inst4_vld_o(v4), .fetch_inst5_vld_o(v5), .fetch_inst6_vld_o(v6), .fetch_inst7_vld_o(v7),
    .pipe_load_decode_o(load)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic model_step();
    logic outstanding;
    logic consumed;
    if (!reset_n) begin
      m_st = 0; m_pc = RESET_PC_TB; m_data = '0; m_vld = 8'h00;
    end else if (retire_flush) begin
      outstanding = (m_st == 1) || (m_st == 3) || (m_st == 0 && ic_gnt);
      consumed    = ic_rsp_vld && (m_st == 1 || m_st == 3);
      m_st  = (outstanding && !consumed) ? 3 : 0;
      m_pc  = flush_pc & ~64'h3;
      m_vld = 8'h00;
    end else begin
      case (m_st)
        0: if (ic_gnt) m_st = 1;
        1: if (ic_rsp_vld) begin
             m_data = ic_rsp_data;
             m_vld  = 8'hFF << m_pc[4:2];
             m_st   = 2;
           end
        2: if (!instbuf_full) begin
             m_pc  = (m_pc & ~64'h1F) + 64'd32;
             m_vld = 8'h00;
             m_st  = 0;
           end
        default: if (ic_rsp_vld) m_st = 0;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    retire_flush = 1'b0; flush_pc = 64'h0; instbuf_full = 1'b0;
    ic_gnt = 1'b0; ic_rsp_vld = 1'b0; ic_rsp_data = 256'h0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear_inputs();
    tick(); tick();
    #1;
    checks++; if (ic_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", ic_req); end
    checks++; if (load !== 1'b0) begin errors++; $display("FAIL reset_load: got %b expected 0", load); end
    checks++; if (vld_all !== 8'h00) begin errors++; $display("FAIL reset_vld: got %h expected 00", vld_all); end
    checks++; if (inst_all !== 256'h0) begin errors++; $display("FAIL reset_inst: got %h expected 0", inst_all); end
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [255:0] blk;
    for (int i = 0; i < 8; i++) blk[32*i +: 32] = $urandom;
    ic_gnt = 1'b1; #1;
    checks++; if (ic_req !== 1'b1) begin errors++; $display("FAIL basic_req: got %b expected 1", ic_req); end
    checks++; if (ic_addr !== 64'h1000) begin errors++; $display("FAIL basic_addr: got %h expected 1000", ic_addr); end
    tick();
    ic_gnt = 1'b0; ic_rsp_vld = 1'b1; ic_rsp_data = blk; #1;
    checks++; if (ic_req !== 1'b0) begin errors++; $display("FAIL basic_wait_req: got %b expected 0", ic_req); end
    tick();
    ic_rsp_vld = 1'b0; instbuf_full = 1'b0; #1;
    checks++; if (load !== 1'b1) begin errors++; $display("FAIL basic_load: got %b expected 1", load); end
    checks++; if (vld_all !== 8'hFF) begin errors++; $display("FAIL basic_vld: got %h expected ff", vld_all); end
    checks++; if (inst_all !== blk) begin errors++; $display("FAIL basic_data: got %h expected %h", inst_all, blk); end
    tick(); #1;
    checks++; if (ic_req !== 1'b1 || ic_addr !== 64'h1020) begin errors++; $display("FAIL basic_next: got req=%b addr=%h expected req=1 addr=1020", ic_req, ic_addr); end
  endtask

  task automatic test_flush_mid_and_stall();
    logic [255:0] blk;
    for (int i = 0; i < 8; i++) blk[32*i +: 32] = $urandom;
    retire_flush = 1'b1; flush_pc = 64'h2014; #1;
    checks++; if (load !== 1'b0) begin errors++; $display("FAIL mid_flush_load: got %b expected 0", load); end
    tick();
    retire_flush = 1'b0; ic_gnt = 1'b1; #1;
    checks++; if (ic_addr !== 64'h2000) begin errors++; $display("FAIL mid_addr: got %h expected 2000", ic_addr); end
    tick();
    ic_gnt = 1'b0; ic_rsp_vld = 1'b1; ic_rsp_data = blk;
    tick();
    ic_rsp_vld = 1'b0; instbuf_full = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (load !== 1'b0) begin errors++; $display("FAIL stall_load: got %b expected 0", load); end
      checks++; if (vld_all !== 8'hE0) begin errors++; $display("FAIL stall_vld: got %h expected e0", vld_all); end
      checks++; if (inst_all !== blk) begin errors++; $display("FAIL stall_data: got %h expected %h", inst_all, blk); end
      tick();
    end
    instbuf_full = 1'b0; #1;
    checks++; if (load !== 1'b1) begin errors++; $display("FAIL stall_release: got %b expected 1", load); end
    tick(); #1;
    checks++; if (ic_req !== 1'b1 || ic_addr !== 64'h2020) begin errors++; $display("FAIL stall_next: got req=%b addr=%h expected req=1 addr=2020", ic_req, ic_addr); end
  endtask

  task automatic test_flush_wait();
    ic_gnt = 1'b1;
    tick();
    ic_gnt = 1'b0; retire_flush = 1'b1; flush_pc = 64'h3000; #1;
    checks++; if (ic_req !== 1'b0 || load !== 1'b0) begin errors++; $display("FAIL fw_flush: got req=%b load=%b expected 0 0", ic_req, load); end
    tick();
    retire_flush = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (ic_req !== 1'b0 || load !== 1'b0) begin errors++; $display("FAIL fw_drain: got req=%b load=%b expected 0 0", ic_req, load); end
      tick();
    end
    ic_rsp_vld = 1'b1; ic_rsp_data = {8{32'hDEADBEEF}}; #1;
    checks++; if (ic_req !== 1'b0 || load !== 1'b0) begin errors++; $display("FAIL fw_rsp: got req=%b load=%b expected 0 0", ic_req, load); end
    tick();
    ic_rsp_vld = 1'b0; #1;
    checks++; if (ic_req !== 1'b1 || ic_addr !== 64'h3000 || vld_all !== 8'h00) begin errors++; $display("FAIL fw_after: got req=%b addr=%h vld=%h expected 1 3000 00", ic_req, ic_addr, vld_all); end
  endtask

  task automatic test_flush_rsp_and_present();
    ic_gnt = 1'b1;
    tick();
    ic_gnt = 1'b0; ic_rsp_vld = 1'b1; ic_rsp_data = {8{32'h12345678}};
    retire_flush = 1'b1; flush_pc = 64'h4008; #1;
    checks++; if (load !== 1'b0) begin errors++; $display("FAIL fr_load: got %b expected 0", load); end
    tick();
    ic_rsp_vld = 1'b0; retire_flush = 1'b0; #1;
    checks++; if (ic_req !== 1'b1 || ic_addr !== 64'h4000 || vld_all !== 8'h00) begin errors++; $display("FAIL fr_after: got req=%b addr=%h vld=%h expected 1 4000 00", ic_req, ic_addr, vld_all); end
    ic_gnt = 1'b1;
    tick();
    ic_gnt = 1'b0; ic_rsp_vld = 1'b1; ic_rsp_data = {8{32'hCAFEF00D}};
    tick();
    ic_rsp_vld = 1'b0; instbuf_full = 1'b0; retire_flush = 1'b1; flush_pc = 64'h5000; #1;
    checks++; if (load !== 1'b0 || vld_all !== 8'hFC) begin errors++; $display("FAIL fp_load: got load=%b vld=%h expected 0 fc", load, vld_all); end
    tick();
    retire_flush = 1'b0; #1;
    checks++; if (ic_req !== 1'b1 || ic_addr !== 64'h5000 || vld_all !== 8'h00) begin errors++; $display("FAIL fp_after: got req=%b addr=%h vld=%h expected 1 5000 00", ic_req, ic_addr, vld_all); end
  endtask

  task automatic test_wrap_and_hold();
    retire_flush = 1'b1; flush_pc = 64'h6000;
    tick();
    flush_pc = 64'hFFFF_FFFF_FFFF_FFE0;
    tick();
    retire_flush = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (ic_req !== 1'b1 || ic_addr !== 64'hFFFF_FFFF_FFFF_FFE0) begin errors++; $display("FAIL hold_addr: got req=%b addr=%h expected 1 ffffffffffffffe0", ic_req, ic_addr); end
      tick();
    end
    ic_gnt = 1'b1;
    tick();
    ic_gnt = 1'b0; ic_rsp_vld = 1'b1; ic_rsp_data = {8{32'h0BADC0DE}};
    tick();
    ic_rsp_vld = 1'b0; #1;
    checks++; if (load !== 1'b1) begin errors++; $display("FAIL wrap_load: got %b expected 1", load); end
    tick(); #1;
    checks++; if (ic_req !== 1'b1 || ic_addr !== 64'h0) begin errors++; $display("FAIL wrap_addr: got req=%b addr=%h expected 1 0", ic_req, ic_addr); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      instbuf_full = ($urandom_range(0, 9) < 3);
      ic_gnt       = (m_st == 0) && ($urandom_range(0, 2) != 0);
      ic_rsp_vld   = (m_st == 1 || m_st == 3) && ($urandom_range(0, 2) != 0);
      retire_flush = ($urandom_range(0, 19) == 0) && !(m_st == 3 && ic_rsp_vld);
      flush_pc     = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) flush_pc[63:16] = 48'hFFFF_FFFF_FFFF;
      for (int i = 0; i < 8; i++) ic_rsp_data[32*i +: 32] = $urandom;
      #1;
      checks++; if (ic_req !== (m_st == 0)) begin errors++; $display("FAIL rnd_req c=%0d: got %b expected %b", c, ic_req, (m_st == 0)); end
      checks++; if (ic_addr !== (m_pc & ~64'h1F)) begin errors++; $display("FAIL rnd_addr c=%0d: got %h expected %h", c, ic_addr, m_pc & ~64'h1F); end
      checks++; if (load !== (m_st == 2 && !instbuf_full && !retire_flush)) begin errors++; $display("FAIL rnd_load c=%0d: got %b expected %b", c, load, (m_st == 2 && !instbuf_full && !retire_flush)); end
      checks++; if (vld_all !== m_vld) begin errors++; $display("FAIL rnd_vld c=%0d: got %h expected %h", c, vld_all, m_vld); end
      checks++; if (m_vld != 8'h00 && inst_all !== m_data) begin errors++; $display("FAIL rnd_data c=%0d: got %h expected %h", c, inst_all, m_data); end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flush_mid_and_stall();
    test_flush_wait();
    test_flush_rsp_and_present();
    test_wrap_and_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ace_fetch.md
# ace_fetch

Front-end fetch controller that generates the fetch PC, requests 32-byte aligned fetch blocks from the instruction cache, and presents up to eight 32-bit instructions with per-slot valid bits to the decode stage's instruction buffer. It drives the `fetch_inst*` / `pipe_load_decode` side of the decode interface. It stalls on instruction-buffer back-pressure and redirects on retire flush.

## Interface
Parameters:
- `RESET_PC`, default `64'h0`: fetch PC after reset.
- `PC_W`, default `64`: PC width.

Ports:
- `clock` in 1: single clock.
- `reset_n` in 1: synchronous, active-low reset.
- `retire_flush_i` in 1: redirect request from retire.
- `flush_pc_i` in PC_W: redirect target. Bits [1:0] are ignored.
- `instbuf_full_i` in 1: decode instruction buffer full.
- `ic_req_o` out 1: icache request valid.
- `ic_addr_o` out PC_W: request address, equal to `{pc[PC_W-1:5], 5'b0}`.
- `ic_gnt_i` in 1: request accepted. At most one request is outstanding.
- `ic_rsp_vld_i` in 1: response data valid.
- `ic_rsp_data_i` in 256: fetch block. Slot i is `data[32i+31:32i]`.
- `fetch_inst0_o` … `fetch_inst7_o` out 32 each: packet instructions.
- `fetch_inst0_vld_o` … `fetch_inst7_vld_o` out 1 each: slot valid.
- `pipe_load_decode_o` out 1: packet transferred to the buffer this cycle.

## Operation
The block has four states:
- REQ
- WAIT
- PRESENT
- DRAIN

Reset (`reset_n`=0 at a clock edge):
- State goes to REQ and pc goes to `RESET_PC`.
- All `fetch_inst*_o` and `*_vld_o` are 0.
- `ic_req_o`=0 and `pipe_load_decode_o`=0 while `reset_n` is low.

State behaviour:
- REQ: `ic_req_o`=1 and `ic_addr_o` holds the aligned pc. On `ic_gnt_i`, go to WAIT. The request stays asserted and stable until granted.
- WAIT: on `ic_rsp_vld_i`, register the eight instructions and set `vld[i] = (i >= pc[4:2])`, then go to PRESENT. Entry into the block at a mid-line PC therefore invalidates the leading slots.
- PRESENT: `pipe_load_decode_o = !instbuf_full_i`.
  - If not full: the packet transfers, pc becomes `{pc[PC_W-1:5],5'b0} + 32`, all valid bits clear, and the state goes to REQ.
  - If full: hold the packet and valid bits unchanged.
- DRAIN: discard the response still outstanding after a flush. On `ic_rsp_vld_i`, go to REQ with the data dropped.

PC arithmetic:
- PC arithmetic is modulo 2^PC_W.
- Incrementing from the last block wraps to 0.

Flush (`retire_flush_i`) has priority over everything except reset:
- pc becomes `{flush_pc_i[PC_W-1:2], 2'b00}`.
- All valid bits clear.
- `pipe_load_decode_o` is forced to 0 in the flush cycle.
- Next state:
  - REQ from REQ or PRESENT. A REQ that is granted in the same cycle as the flush counts as outstanding and goes to DRAIN instead.
  - DRAIN from WAIT, unless `ic_rsp_vld_i` is also 1 that cycle, in which case the response is discarded and the next state is REQ.
  - DRAIN stays DRAIN.
- Back-to-back flushes: the last `flush_pc_i` wins.

## Timing
- State, pc, packet registers and valid bits are all registered.
- `ic_req_o` is decoded from state.
- `pipe_load_decode_o` is combinational from state, `instbuf_full_i` and `retire_flush_i`.
- Minimum latency: grant at cycle N, response at N+1, packet presented with `pipe_load_decode_o`=1 at N+2, next `ic_req_o` at N+3.
- Throughput with an ideal cache: one packet per 3 cycles.
- `fetch_inst*_o` / `*_vld_o` are stable from PRESENT entry until transfer or flush.
- A response in any state other than WAIT or DRAIN is a protocol error. It is ignored and flagged by an assertion.

## Structure
- Shared package `ace_fetch_pkg`:
  - `FETCH_WIDTH=8`
  - `FETCH_BLK_BYTES=32`
  - the fetch state enum `fetch_state_e` (REQ, WAIT, PRESENT, DRAIN)
  - `RESET_PC` default
- Optional sub-module `fetch_slot_mask`: combinational, pc[4:2] → 8-bit valid mask.
- Everything else is flat in `ace_fetch`.

## Test plan
- Reset with `RESET_PC=64'h1000`, immediate grant, response at N+1 → `ic_addr_o=64'h1000`, all eight valid bits set, `pipe_load_decode_o`=1 at N+2, next `ic_addr_o=64'h1020`.
- Flush to `flush_pc_i=64'h2014`, then respond → `ic_addr_o=64'h2000`, valid bits = `8'b1110_0000` (slots 5–7 only).
- Assert `instbuf_full_i` for 4 cycles in PRESENT → `pipe_load_decode_o`=0 and data/valid bits held; transfer happens on the first cycle full is low.
- Flush while in WAIT, response 3 cycles later → response discarded, no `pipe_load_decode_o`, new request to the flush target only after DRAIN exits.
- Flush in the same cycle as `ic_rsp_vld_i` in WAIT → data dropped and the next cycle is REQ to the flush target. Separately, flush in PRESENT with full low → `pipe_load_decode_o`=0 in that cycle.
- `pc=64'hFFFF_FFFF_FFFF_FFE0` packet transfers → next `ic_addr_o=64'h0`. Also hold the request ungranted for 5 cycles → address stable.
